// File: rtl/divider_pkg.sv
// divider_pkg: shared state encoding and constants for the iterative divider
package divider_pkg;
  localparam int SW = 3;
  typedef enum logic [SW-1:0] {S_IDLE, S_LOAD, S_ITER, S_FIX, S_DONE} state_t;
  localparam logic [63:0] DBZ_Q = '1;
endpackage

// File: rtl/divider_fsm.sv
// divider_fsm: controller sequencing load, N restoring iterations, sign fix and done handshake
module divider_fsm
  import divider_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic E,
  input  logic zC,
  input  logic bz,
  input  logic cout,
  output logic LAB,
  output logic EA,
  output logic EC,
  output logic sclrR,
  output logic LR,
  output logic ER,
  output logic EF,
  output logic done,
  output logic busy
);
  state_t state, nxt;
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= S_IDLE;
      done  <= 1'b0;
      busy  <= 1'b0;
    end else begin
      state <= nxt;
      done  <= state == S_DONE;
      busy  <= state inside {S_LOAD, S_ITER, S_FIX};
    end
  end
  always_comb begin
    nxt   = state;
    LAB   = state == S_IDLE && E;
    sclrR = state == S_LOAD;
    EA    = state == S_ITER;
    EC    = state == S_ITER;
    ER    = state == S_ITER;
    LR    = state == S_ITER && cout;
    EF    = state == S_FIX;
    case (state)
      S_IDLE:  nxt = E ? S_LOAD : S_IDLE;
      S_LOAD:  nxt = bz ? S_DONE : S_ITER;
      S_ITER:  nxt = zC ? S_FIX : S_ITER;
      S_FIX:   nxt = S_DONE;
      S_DONE:  nxt = E ? S_DONE : S_IDLE;
      default: nxt = S_IDLE;
    endcase
  end
endmodule

// File: rtl/iterative_divider_n.sv
// iterative_divider_n: N-bit restoring divider with signed mode, divide-by-zero flag and busy/done handshake
module iterative_divider_n
  import divider_pkg::*;
#(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         E,
  input  logic         sgn,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  output logic [N-1:0] Q,
  output logic [N-1:0] R,
  output logic         busy,
  output logic         done,
  output logic         dbz
);
  localparam int CW = $clog2(N);
  logic [N-1:0] a_l, b_l, areg, breg, rreg, diff, a_mag, b_mag;
  logic [N:0] rp;
  logic [CW-1:0] cnt;
  logic s_l, neg_q, neg_r, zC, bz, cout;
  logic LAB, EA, EC, sclrR, LR, ER, EF;
  assign bz    = b_l == '0;
  assign zC    = cnt == '0;
  assign rp    = {rreg, areg[N-1]};
  assign diff  = rp[N-1:0] - breg;
  assign cout  = rp >= {1'b0, breg};
  assign a_mag = s_l && a_l[N-1] ? -a_l : a_l;
  assign b_mag = s_l && b_l[N-1] ? -b_l : b_l;
  divider_fsm u_fsm (
    .clk(clk), .reset(reset), .E(E), .zC(zC), .bz(bz), .cout(cout),
    .LAB(LAB), .EA(EA), .EC(EC), .sclrR(sclrR), .LR(LR), .ER(ER), .EF(EF),
    .done(done), .busy(busy)
  );
  always_ff @(posedge clk) begin
    if (!reset) begin
      a_l   <= '0;
      b_l   <= '0;
      s_l   <= 1'b0;
      areg  <= '0;
      breg  <= '0;
      rreg  <= '0;
      cnt   <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      Q     <= '0;
      R     <= '0;
      dbz   <= 1'b0;
    end else begin
      if (LAB) begin
        a_l <= A;
        b_l <= B;
        s_l <= sgn;
        dbz <= 1'b0;
      end
      if (sclrR) begin
        if (bz) begin
          Q   <= DBZ_Q[N-1:0];
          R   <= a_l;
          dbz <= 1'b1;
        end
        areg  <= a_mag;
        breg  <= b_mag;
        rreg  <= '0;
        cnt   <= CW'(N - 1);
        neg_q <= s_l & (a_l[N-1] ^ b_l[N-1]);
        neg_r <= s_l & a_l[N-1];
      end
      // quotient bits shift into the dividend register as it empties
      if (ER) rreg <= LR ? diff : rp[N-1:0];
      if (EA) areg <= {areg[N-2:0], LR};
      if (EC) cnt <= cnt - CW'(1);
      if (EF) begin
        Q <= neg_q ? -areg : areg;
        R <= neg_r ? -rreg : rreg;
      end
    end
  end
endmodule

// File: tb/tb_iterative_divider_n.sv
// tb_iterative_divider_n: randomized scoreboard bench for 8- and 16-bit dividers against a truncating-division model
module tb_iterative_divider_n;
  logic clk = 0, rst_n = 0;
  always #5 clk = ~clk;
  logic E8 = 0, s8 = 0, E16 = 0, s16 = 0;
  logic [7:0] A8 = 0, B8 = 0, Q8, R8;
  logic [15:0] A16 = 0, B16 = 0, Q16, R16;
  logic busy8, done8, dbz8, busy16, done16, dbz16;
  iterative_divider_n #(.N(8)) dut8 (
    .clk(clk), .reset(rst_n), .E(E8), .sgn(s8), .A(A8), .B(B8),
    .Q(Q8), .R(R8), .busy(busy8), .done(done8), .dbz(dbz8)
  );
  iterative_divider_n #(.N(16)) dut16 (
    .clk(clk), .reset(rst_n), .E(E16), .sgn(s16), .A(A16), .B(B16),
    .Q(Q16), .R(R16), .busy(busy16), .done(done16), .dbz(dbz16)
  );
  typedef struct {
    logic [63:0] q, r;
    bit z;
    int lat;
    longint st;
  } exp_t;
  exp_t q8[$], q16[$];
  int tests = 0, fails = 0;
  longint cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, expv);
    end
  endtask

  function automatic exp_t model(input int w, input bit s, input logic [63:0] a, input logic [63:0] b);
    exp_t e;
    logic [63:0] m = (64'd1 << w) - 64'd1;
    longint p = longint'(64'd1 << w);
    longint sa, sb;
    e.st = 0;
    if (b == 0) begin
      e.q = m; e.r = a; e.z = 1; e.lat = 2;
    end else begin
      sa = s && a[w-1] ? $signed(a) - p : $signed(a);
      sb = s && b[w-1] ? $signed(b) - p : $signed(b);
      e.q = 64'(sa / sb) & m;
      e.r = 64'(sa % sb) & m;
      e.z = 0;
      e.lat = w + 3;
    end
    return e;
  endfunction

  task automatic got(input int w, input logic [63:0] qv, input logic [63:0] rv, input logic zv, input int bc);
    exp_t e;
    if ((w == 8 ? q8.size() : q16.size()) == 0) begin
      tests++; fails++;
      $display("FAIL unexpected_done_n%0d: got done rising, expected no operation pending", w);
      return;
    end
    if (w == 8) e = q8.pop_front(); else e = q16.pop_front();
    chk($sformatf("quotient_n%0d", w), qv, e.q);
    chk($sformatf("remainder_n%0d", w), rv, e.r);
    chk($sformatf("dbz_n%0d", w), 64'(zv), 64'(e.z));
    chk($sformatf("latency_n%0d", w), 64'(cyc - e.st), 64'(e.lat));
    chk($sformatf("busy_cycles_n%0d", w), 64'(bc), 64'(e.lat - 1));
  endtask

  int bc8 = 0, bc16 = 0;
  bit pd8 = 0, pd16 = 0;
  always @(negedge clk) begin
    if (!rst_n) begin
      bc8 = 0; pd8 = 0;
    end else begin
      if (busy8) bc8++;
      if (done8 && !pd8) begin
        got(8, 64'(Q8), 64'(R8), dbz8, bc8);
        bc8 = 0;
      end
      pd8 = done8;
    end
  end
  always @(negedge clk) begin
    if (!rst_n) begin
      bc16 = 0; pd16 = 0;
    end else begin
      if (busy16) bc16++;
      if (done16 && !pd16) begin
        got(16, 64'(Q16), 64'(R16), dbz16, bc16);
        bc16 = 0;
      end
      pd16 = done16;
    end
  end

  function automatic logic dn(input int w);
    return w == 8 ? done8 : done16;
  endfunction

  task automatic set_e(input int w, input logic v);
    if (w == 8) E8 = v; else E16 = v;
  endtask

  task automatic scramble(input int w);
    if (w == 8) begin A8 = 8'($urandom); B8 = 8'($urandom); s8 = 1'($urandom); end
    else begin A16 = 16'($urandom); B16 = 16'($urandom); s16 = 1'($urandom); end
  endtask

  // mode 0: one-cycle pulse, 1: E held 40 cycles, 2: E and operands toggled while busy
  task automatic op(input int w, input bit s, input logic [63:0] a0, input logic [63:0] b0, input int mode);
    exp_t e;
    bit seen = 0;
    int k = 0;
    logic [63:0] m = (64'd1 << w) - 64'd1;
    logic [63:0] a = a0 & m, b = b0 & m;
    e = model(w, s, a, b);
    e.st = cyc + 1;
    if (w == 8) begin
      A8 = a[7:0]; B8 = b[7:0]; s8 = s; E8 = 1; q8.push_back(e);
    end else begin
      A16 = a[15:0]; B16 = b[15:0]; s16 = s; E16 = 1; q16.push_back(e);
    end
    while (!seen && k < 40) begin
      @(negedge clk);
      k++;
      seen = dn(w);
      if (!seen && mode == 0) set_e(w, 0);
      if (!seen && mode == 2) begin set_e(w, 1'($urandom)); scramble(w); end
    end
    if (!seen) begin
      tests++; fails++;
      $display("FAIL timeout_n%0d: got done=0 after 40 cycles, expected done=1", w);
      if (w == 8) q8.delete(); else q16.delete();
    end
    if (seen && mode == 1)
      while (k < 40) begin
        @(negedge clk);
        k++;
        chk($sformatf("done_held_n%0d", w), 64'(dn(w)), 64'd1);
      end
    set_e(w, 0);
    @(negedge clk);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_q8"}, 64'(Q8), 0);
    chk({tag, "_r8"}, 64'(R8), 0);
    chk({tag, "_busy8"}, 64'(busy8), 0);
    chk({tag, "_done8"}, 64'(done8), 0);
    chk({tag, "_dbz8"}, 64'(dbz8), 0);
    chk({tag, "_q16"}, 64'(Q16), 0);
    chk({tag, "_done16"}, 64'(done16), 0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk_zero("reset");
    rst_n = 1;
    @(negedge clk);
    op(8, 0, 100, 7, 0);
    op(8, 1, 64'h9C, 7, 0);
    op(8, 1, 100, 64'hF9, 0);
    op(8, 0, 5, 0, 0);
    op(8, 0, 17, 3, 0);
    op(8, 1, 64'h80, 64'hFF, 0);
    op(8, 0, 255, 1, 0);
    A8 = 8'd200; B8 = 8'd3; s8 = 0; E8 = 1;
    @(negedge clk);
    E8 = 0;
    repeat (5) @(negedge clk);
    rst_n = 0;
    @(negedge clk);
    chk_zero("abort");
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    op(8, 0, 20, 3, 0);
    op(8, 0, 45, 6, 1);
    op(8, 1, 64'hC3, 5, 2);
    op(16, 0, 60000, 7, 0);
    op(16, 1, 64'h8000, 64'hFFFF, 1);
    op(16, 0, 1234, 0, 2);
    for (int i = 0; i < 40; i++)
      op(8, 1'($urandom), 64'($urandom), $urandom_range(0, 7) == 0 ? 64'd0 : 64'($urandom), 2 * int'($urandom_range(0, 1)));
    for (int i = 0; i < 12; i++)
      op(16, 1'($urandom), 64'($urandom), $urandom_range(0, 7) == 0 ? 64'd0 : 64'($urandom), 2 * int'($urandom_range(0, 1)));
    repeat (5) @(negedge clk);
    chk("pending_n8", 64'(q8.size()), 0);
    chk("pending_n16", 64'(q16.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
